// File: rtl/retire_map_pkg.sv
// retire_map_pkg: shared rename/retire types and default register-file sizes.
package retire_map_pkg;
    localparam int RETIRE_MAP_NLR = 32;
    localparam int RETIRE_MAP_NPR = 64;
    localparam int LREG_W = $clog2(RETIRE_MAP_NLR);
    localparam int PREG_W = $clog2(RETIRE_MAP_NPR);
    typedef logic [LREG_W-1:0] lreg_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef struct packed {
        logic [15:0] opid;
        logic        rollback;
        logic        redir;
        lreg_t       lrda;
        preg_t       prda;
    } com_bundle_t;
    typedef enum logic {RUN, RESTORE} rm_state_e;
    function automatic int wrap_idx(int base, int off, int depth);
        return (base + off) % depth;
    endfunction
endpackage

// File: rtl/freelist_fifo.sv
// freelist_fifo: circular free list, up to npush compacted pushes and npop pops per cycle.
module freelist_fifo
    import retire_map_pkg::*;
#(
    parameter int depth     = RETIRE_MAP_NPR,
    parameter int npush     = 4,
    parameter int npop      = 4,
    parameter int init_base = RETIRE_MAP_NLR,
    localparam int PW = $clog2(depth),
    localparam int CW = $clog2(depth) + 1,
    localparam int NW = $clog2(npop) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic  [npush-1:0]   push_vld_i,
    input  preg_t [npush-1:0]   push_data_i,
    input  logic  [NW-1:0]      pop_num_i,
    output preg_t [npop-1:0]    pop_data_o,
    output logic  [CW-1:0]      cnt_o
);
    preg_t         mem_q [depth];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d, pops;
    logic [PW-1:0] wr_idx [npush];
    int            npushed;

    always_comb begin
        npushed = 0;
        for (int i = 0; i < npush; i++) begin
            wr_idx[i] = PW'(wrap_idx(int'(tail_q), npushed, depth));
            npushed += int'(push_vld_i[i]);
        end
        pops   = (CW'(pop_num_i) > cnt_q) ? cnt_q : CW'(pop_num_i);
        head_d = PW'(wrap_idx(int'(head_q), int'(pops), depth));
        tail_d = PW'(wrap_idx(int'(tail_q), npushed, depth));
        cnt_d  = CW'(int'(cnt_q) + npushed - int'(pops));
        // Reads see only registered contents: no push-to-pop bypass.
        for (int k = 0; k < npop; k++)
            pop_data_o[k] = (k < int'(cnt_q)) ? mem_q[PW'(wrap_idx(int'(head_q), k, depth))] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= PW'(depth - init_base);
            cnt_q  <= CW'(depth - init_base);
            for (int k = 0; k < depth; k++)
                mem_q[k] <= (k < depth - init_base) ? preg_t'(init_base + k) : '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < npush; i++)
                if (push_vld_i[i]) mem_q[wr_idx[i]] <= push_data_i[i];
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/retire_map.sv
// retire_map: architectural map table, free-list recycling and redirect restore FSM.
// Define RETIRE_MAP_CHECK_EN to add a free bitmap and a sticky consistency error.
module retire_map
    import retire_map_pkg::*;
#(
    parameter int cwd = 4,
    parameter int awd = 4,
    parameter int nlr = RETIRE_MAP_NLR,
    parameter int npr = RETIRE_MAP_NPR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  com_bundle_t [cwd-1:0]   com_bundle,
    input  logic [$clog2(awd):0]    alloc_num,
    output preg_t [awd-1:0]         alloc_preg,
    output logic [$clog2(npr):0]    free_cnt,
    output preg_t [nlr-1:0]         amap,
    output logic                    restore,
    output logic                    err
);
    preg_t [nlr-1:0]      amap_q, amap_d;
    rm_state_e            state_q, state_d;
    logic [cwd-1:0]       push_vld;
    preg_t [cwd-1:0]      push_data;
    logic [$clog2(awd):0] pop_num;
    logic                 unused_opid;

    // Walking amap_d in entry order gives same-cycle forwarding for repeated lrda.
    always_comb begin
        amap_d    = amap_q;
        push_vld  = '0;
        push_data = '0;
        for (int i = 0; i < cwd; i++) begin
            if (com_bundle[i].opid[15] && !com_bundle[i].rollback && !com_bundle[i].redir &&
                com_bundle[i].lrda != '0) begin
                push_data[i] = amap_d[com_bundle[i].lrda];
                push_vld[i]  = push_data[i] != '0;
                amap_d[com_bundle[i].lrda] = com_bundle[i].prda;
            end else if (com_bundle[i].rollback && com_bundle[i].prda != '0) begin
                push_vld[i]  = 1'b1;
                push_data[i] = com_bundle[i].prda;
            end
        end
        state_d = com_bundle[0].redir ? RESTORE : RUN;
        pop_num = restore ? '0 : alloc_num;
    end

    always_comb begin
        unused_opid = 1'b0;
        for (int i = 0; i < cwd; i++) unused_opid ^= ^com_bundle[i].opid[14:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < nlr; r++) amap_q[r] <= preg_t'(r);
            state_q <= RUN;
        end else begin
            amap_q  <= amap_d;
            state_q <= state_d;
        end
    end

    assign amap    = amap_q;
    assign restore = state_q == RESTORE;

    freelist_fifo #(
        .depth(npr), .npush(cwd), .npop(awd), .init_base(nlr)
    ) u_fl (
        .clk(clk),
        .rst(rst),
        .push_vld_i(push_vld),
        .push_data_i(push_data),
        .pop_num_i(pop_num),
        .pop_data_o(alloc_preg),
        .cnt_o(free_cnt)
    );

`ifdef RETIRE_MAP_CHECK_EN
    logic [npr-1:0] free_q, free_d;
    logic           err_q, err_d;
    int             chk_pops, chk_pushed;

    always_comb begin
        free_d     = free_q;
        err_d      = err_q;
        chk_pushed = 0;
        chk_pops   = (int'(pop_num) > int'(free_cnt)) ? int'(free_cnt) : int'(pop_num);
        for (int k = 0; k < awd; k++)
            if (k < chk_pops) free_d[alloc_preg[k]] = 1'b0;
        for (int i = 0; i < cwd; i++)
            if (push_vld[i]) begin
                err_d |= free_d[push_data[i]];
                free_d[push_data[i]] = 1'b1;
                chk_pushed++;
            end
        err_d |= (int'(free_cnt) + chk_pushed - chk_pops > npr) || (int'(pop_num) > int'(free_cnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < npr; b++) free_q[b] <= b >= nlr;
            err_q <= 1'b0;
        end else begin
            free_q <= free_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_retire_map.sv
// tb_retire_map: directed vector table plus wrap, reset-override and error sequences.
module tb_retire_map;
    import retire_map_pkg::*;

    typedef com_bundle_t [3:0] bnd_t;
    typedef preg_t [3:0] ap_t;
    typedef struct {
        bnd_t       cb;
        logic [2:0] an;
        ap_t        ap;
        int         fc;
        bit         rs;
        bit         er;
        int         lr;
        int         mp;
    } vec_t;

`ifdef RETIRE_MAP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam com_bundle_t Z = '0;
    localparam bnd_t N = '0;

    logic        clk = 1'b0;
    logic        rst;
    bnd_t        cb;
    logic [2:0]  an;
    ap_t         ap;
    logic [6:0]  fc;
    preg_t [31:0] amap;
    logic        rs, er;
    int          n_vec = 0, n_bad = 0;
    vec_t        tbl [24];

    always #5 clk = ~clk;

    retire_map #(.cwd(4), .awd(4), .nlr(32), .npr(64)) dut (
        .clk(clk), .rst(rst), .com_bundle(cb), .alloc_num(an),
        .alloc_preg(ap), .free_cnt(fc), .amap(amap), .restore(rs), .err(er)
    );

    function automatic com_bundle_t cm(int lr, int pr);
        cm = '0;
        cm.opid = 16'h8000;
        cm.lrda = lreg_t'(lr);
        cm.prda = preg_t'(pr);
    endfunction

    function automatic com_bundle_t iv(int lr, int pr);
        iv = cm(lr, pr);
        iv.opid = 16'h0000;
    endfunction

    function automatic com_bundle_t rb(int pr);
        rb = cm(9, pr);
        rb.rollback = 1'b1;
    endfunction

    function automatic com_bundle_t rd(int lr, int pr, bit rbk);
        rd = cm(lr, pr);
        rd.redir = 1'b1;
        rd.rollback = rbk;
    endfunction

    function automatic bnd_t b4(com_bundle_t e0, com_bundle_t e1, com_bundle_t e2, com_bundle_t e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic ap_t p4(int a, int b, int c, int d);
        return {preg_t'(d), preg_t'(c), preg_t'(b), preg_t'(a)};
    endfunction

    function automatic vec_t v(bnd_t c, int a, ap_t p, int f, bit r, bit e, int l, int m);
        v.cb = c; v.an = 3'(a); v.ap = p; v.fc = f; v.rs = r; v.er = e; v.lr = l; v.mp = m;
    endfunction

    task automatic step(bnd_t c, int a);
        cb = c;
        an = 3'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, ap_t eap, int efc, bit ers, bit eer, int lr, int emp);
        logic [4:0] li;
        li = lr[4:0];
        n_vec++;
        if (ap !== eap || fc !== 7'(efc) || rs !== ers || er !== eer || amap[li] !== preg_t'(emp)) begin
            n_bad++;
            $display("FAIL %s: got ap={%0d,%0d,%0d,%0d} fc=%0d restore=%0b err=%0b amap[%0d]=%0d; want ap={%0d,%0d,%0d,%0d} fc=%0d restore=%0b err=%0b amap=%0d",
                     nm, ap[0], ap[1], ap[2], ap[3], fc, rs, er, lr, amap[li],
                     eap[0], eap[1], eap[2], eap[3], efc, ers, eer, emp);
        end
    endtask

    initial begin
        tbl[0]  = v(N, 0, p4(32, 33, 34, 35), 32, 0, 0, 5, 5);
        tbl[1]  = v(N, 4, p4(36, 37, 38, 39), 28, 0, 0, 5, 5);
        tbl[2]  = v(N, 4, p4(40, 41, 42, 43), 24, 0, 0, 5, 5);
        tbl[3]  = v(N, 4, p4(44, 45, 46, 47), 20, 0, 0, 5, 5);
        tbl[4]  = v(b4(cm(5, 40), Z, Z, Z), 0, p4(44, 45, 46, 47), 21, 0, 0, 5, 40);
        tbl[5]  = v(b4(cm(7, 41), cm(7, 42), Z, Z), 0, p4(44, 45, 46, 47), 23, 0, 0, 7, 42);
        tbl[6]  = v(b4(iv(7, 43), Z, Z, Z), 0, p4(44, 45, 46, 47), 23, 0, 0, 7, 42);
        tbl[7]  = v(b4(cm(0, 43), Z, Z, Z), 0, p4(44, 45, 46, 47), 23, 0, 0, 0, 0);
        tbl[8]  = v(b4(rb(0), Z, rb(43), Z), 0, p4(44, 45, 46, 47), 24, 0, 0, 7, 42);
        tbl[9]  = v(b4(cm(1, 32), rb(33), Z, cm(2, 34)), 4, p4(48, 49, 50, 51), 23, 0, 0, 1, 32);
        tbl[10] = v(b4(rd(3, 44, 0), Z, Z, Z), 0, p4(48, 49, 50, 51), 23, 1, 0, 3, 3);
        tbl[11] = v(N, 2, p4(48, 49, 50, 51), 23, 0, 0, 2, 34);
        tbl[12] = v(N, 2, p4(50, 51, 52, 53), 21, 0, 0, 5, 40);
        tbl[13] = v(b4(rd(3, 44, 0), Z, Z, Z), 0, p4(50, 51, 52, 53), 21, 1, 0, 3, 3);
        tbl[14] = v(b4(rd(3, 44, 0), Z, Z, Z), 3, p4(50, 51, 52, 53), 21, 1, 0, 3, 3);
        tbl[15] = v(N, 0, p4(50, 51, 52, 53), 21, 0, 0, 3, 3);
        tbl[16] = v(b4(rd(3, 35, 1), Z, Z, Z), 0, p4(50, 51, 52, 53), 22, 1, 0, 3, 3);
        tbl[17] = v(N, 0, p4(50, 51, 52, 53), 22, 0, 0, 3, 3);
        tbl[18] = v(N, 4, p4(54, 55, 56, 57), 18, 0, 0, 5, 40);
        tbl[19] = v(N, 4, p4(58, 59, 60, 61), 14, 0, 0, 5, 40);
        tbl[20] = v(N, 4, p4(62, 63, 5, 7), 10, 0, 0, 5, 40);
        tbl[21] = v(N, 4, p4(41, 43, 1, 33), 6, 0, 0, 7, 42);
        tbl[22] = v(N, 4, p4(2, 35, 0, 0), 2, 0, 0, 2, 34);
        tbl[23] = v(N, 4, p4(0, 0, 0, 0), 0, 0, CHK, 1, 32);

        rst = 1'b1;
        cb  = N;
        an  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].cb, int'(tbl[i].an));
            check($sformatf("vec%0d", i), tbl[i].ap, tbl[i].fc, tbl[i].rs, tbl[i].er, tbl[i].lr, tbl[i].mp);
        end

        // Empty list at index 40: refill 24 entries so the tail wraps, then 4 more land at 0..3.
        for (int j = 0; j < 6; j++) begin
            step(b4(rb(32 + 4*j), rb(33 + 4*j), rb(34 + 4*j), rb(35 + 4*j)), 0);
            check($sformatf("wrap_fill%0d", j), p4(32, 33, 34, 35), 4*(j + 1), 0, CHK, 5, 40);
        end
        step(b4(rb(56), rb(57), rb(58), rb(59)), 4);
        check("push_pop_same", p4(36, 37, 38, 39), 24, 0, CHK, 5, 40);
        for (int j = 0; j < 5; j++) begin
            step(N, 4);
            check($sformatf("wrap_drain%0d", j), p4(40 + 4*j, 41 + 4*j, 42 + 4*j, 43 + 4*j), 20 - 4*j, 0, CHK, 5, 40);
        end
        step(N, 4);
        check("wrap_empty", p4(0, 0, 0, 0), 0, 0, CHK, 5, 40);

        rst = 1'b1;
        step(b4(rd(5, 60, 0), cm(5, 61), rb(10), Z), 4);
        rst = 1'b0;
        check("reset_override", p4(32, 33, 34, 35), 32, 0, 0, 5, 5);

        step(b4(rb(33), Z, Z, Z), 0);
        check("dup_push", p4(32, 33, 34, 35), 33, 0, CHK, 5, 5);
        step(N, 0);
        check("err_sticky", p4(32, 33, 34, 35), 33, 0, CHK, 5, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
